lsu_mem_stage: RTL and testbench

Load/store unit for the MEM stage of the simple pipeline. It turns the ALU-computed address, store data and funct3 into a handshaked data-memory bus transaction with byte enables. It aligns and sign/zero-extends load data into `data_memory_output`, the load input of the writeback select mux. It stalls the pipeline until the access completes and flags misaligned or illegal accesses without touching memory.

---
 rtl/lsu_mem_stage.sv | 196 +++++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_stage
// Brief    : MEM-stage load/store unit. Issues a handshaked data-bus access
//            with byte enables, aligns and extends load data, stalls the
//            pipeline while the access is in flight and flags illegal
//            accesses without touching memory.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata,
  output logic [31:0]       data_memory_output,
  output logic              lsu_stall,
  output logic              misaligned
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [3:0]          bus_be_q, bus_be_d;
  logic [31:0]         bus_wdata_q, bus_wdata_d;
  logic [31:0]         dmo_q, dmo_d;
  logic                misaligned_q, misaligned_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [1:0]          off_q, off_d;

  logic                w_access;
  logic                w_legal;
  logic [3:0]          w_be;
  logic [31:0]         w_wdata;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [31:0]         w_load;

  assign w_access = mem_rd | mem_wr;

  // Legality: supported size codes, no unsigned variants on stores, natural alignment
  always_comb begin
    w_legal = 1'b0;
    case (funct3)
      3'b000, 3'b100: w_legal = 1'b1;
      3'b001, 3'b101: w_legal = ~addr[0];
      3'b010:         w_legal = (addr[1:0] == 2'b00);
      default:        w_legal = 1'b0;
    endcase
    if (mem_wr && funct3[2]) begin
      w_legal = 1'b0;
    end
  end

  // Byte-lane enables and lane-replicated store data for the requested size
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << addr[1:0];
        w_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {addr[1], 1'b0};
        w_wdata = {2{store_data[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = store_data;
      end
    endcase
  end

  // Load alignment and extension, using the access info captured at issue
  always_comb begin
    w_byte = bus_rdata[{off_q, 3'b000} +: 8];
    w_half = bus_rdata[{off_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'd0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = bus_rdata;
    endcase
  end

  // Next-state and next-output computation for the access sequencer
  always_comb begin
    state_d      = state_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_be_d     = bus_be_q;
    bus_wdata_d  = bus_wdata_q;
    dmo_d        = dmo_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    misaligned_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_access && w_legal) begin
          state_d     = ST_REQ;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_wr;
          bus_addr_d  = {addr[ADDR_W-1:2], 2'b00};
          bus_be_d    = w_be;
          bus_wdata_d = w_wdata;
          funct3_d    = funct3;
          off_d       = addr[1:0];
        end else if (w_access) begin
          misaligned_d = 1'b1;
        end
      end
      ST_REQ: begin
        if (bus_gnt) begin
          state_d   = ST_WAIT;
          bus_req_d = 1'b0;
        end
      end
      ST_WAIT: begin
        if (bus_rvalid) begin
          state_d = ST_DONE;
          if (!bus_we_q) begin
            dmo_d = w_load;
          end
        end
      end
      default: begin
        // DONE: the instruction leaves the stage now, nothing new starts here
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_be_q     <= 4'd0;
      bus_wdata_q  <= 32'd0;
      dmo_q        <= 32'd0;
      misaligned_q <= 1'b0;
      funct3_q     <= 3'd0;
      off_q        <= 2'd0;
    end else begin
      state_q      <= state_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_be_q     <= bus_be_d;
      bus_wdata_q  <= bus_wdata_d;
      dmo_q        <= dmo_d;
      misaligned_q <= misaligned_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
    end
  end

  assign bus_req            = bus_req_q;
  assign bus_we             = bus_we_q;
  assign bus_addr           = bus_addr_q;
  assign bus_be             = bus_be_q;
  assign bus_wdata          = bus_wdata_q;
  assign data_memory_output = dmo_q;
  assign misaligned         = misaligned_q;

  // Stall while an access is in flight, or is about to start from IDLE
  assign lsu_stall = ~rst & ((state_q == ST_REQ) || (state_q == ST_WAIT) ||
                             ((state_q == ST_IDLE) && w_access && w_legal));

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_stage
// Brief    : Self-checking bench for lsu_mem_stage: directed vector table,
//            randomized accesses against a reference model, reset corners.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd, mem_wr;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;
  logic [31:0] data_memory_output;
  logic        lsu_stall, misaligned;

  lsu_mem_stage #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr), .funct3(funct3),
    .addr(addr), .store_data(store_data), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .data_memory_output(data_memory_output), .lsu_stall(lsu_stall),
    .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] model_dmo;

  // per-access observations
  int          r_stall, r_mis, r_req;
  bit          r_have, r_stable, r_timeout;
  logic [31:0] r_dmo, r_addr, r_wd;
  logic [3:0]  r_be;
  logic        r_we;

  typedef struct {
    bit          rd, wr;
    logic [2:0]  f3;
    logic [31:0] a, sd, rdat;
    int          gd, rdl;
    bit          lg;
    logic [3:0]  be;
    logic [31:0] ad, wd, dmo;
    int          stall;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  function automatic vec_t mkv(bit rd, bit wr, logic [2:0] f3, logic [31:0] a, logic [31:0] sd,
                               logic [31:0] rdat, int gd, int rdl, bit lg, logic [3:0] be,
                               logic [31:0] ad, logic [31:0] wd, logic [31:0] dmo, int st);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.a = a; v.sd = sd; v.rdat = rdat;
    v.gd = gd; v.rdl = rdl; v.lg = lg; v.be = be; v.ad = ad; v.wd = wd;
    v.dmo = dmo; v.stall = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: access size in bytes, natural alignment, arithmetic extension
  function automatic void model(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] sd, input logic [31:0] rdat,
                                input logic [31:0] prev, output bit lg, output logic [3:0] be,
                                output logic [31:0] wd, output logic [31:0] dmo);
    int nb, off;
    longint unsigned v, span;
    off = int'(a % 4);
    case (f3)
      3'd0, 3'd4: nb = 1;
      3'd1, 3'd5: nb = 2;
      default:    nb = 4;
    endcase
    lg = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) && !(wr && f3 >= 3'd4) && (off % nb == 0);
    be = 4'(((1 << nb) - 1) << off);
    if (nb == 1)      wd = sd[7:0] * 32'h0101_0101;
    else if (nb == 2) wd = sd[15:0] * 32'h0001_0001;
    else              wd = sd;
    dmo = prev;
    if (lg && !wr) begin
      span = 64'd1 << (8 * nb);
      v = (64'(rdat) >> (8 * off)) % span;
      if (f3 < 3'd4 && nb < 4 && v >= span / 2) v = v + 64'h1_0000_0000 - span;
      dmo = v[31:0];
    end
  endfunction

  task automatic observe();
    if (misaligned) r_mis++;
    if (lsu_stall) r_stall++;
    if (bus_req) begin
      r_req++;
      if (!r_have) begin
        r_have = 1; r_addr = bus_addr; r_be = bus_be; r_we = bus_we; r_wd = bus_wdata;
      end else if (bus_addr !== r_addr || bus_be !== r_be || bus_we !== r_we ||
                   bus_wdata !== r_wd) begin
        r_stable = 0;
      end
    end
  endtask

  // Present one MEM instruction, act as the bus slave, hold it while stalled
  task automatic run_access(input bit rd, input bit wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdat,
                            input int gd, input int rdl, input int trail, input bit noise);
    int req_cnt = 0;
    int since = 0;
    bit granted = 0;
    bit rv_done = 0;
    bit left = 0;
    r_stall = 0; r_mis = 0; r_req = 0; r_have = 0; r_stable = 1; r_dmo = 'x;
    r_addr = 'x; r_be = 'x; r_we = 'x; r_wd = 'x;
    mem_rd = rd; mem_wr = wr; funct3 = f3; addr = a; store_data = sd;
    for (int cyc = 0; cyc < 64 && !left; cyc++) begin
      bus_gnt = 0; bus_rvalid = 0; bus_rdata = $urandom;
      if (bus_req && !granted) begin
        if (req_cnt == gd) begin
          bus_gnt = 1; granted = 1;
        end else if (noise) begin
          bus_rvalid = 1'($urandom % 2);
        end
        req_cnt++;
      end else if (granted && !rv_done) begin
        since++;
        if (since == rdl) begin
          bus_rvalid = 1; bus_rdata = rdat; rv_done = 1;
        end
      end else if (noise) begin
        bus_rvalid = 1'($urandom % 2);
      end
      #1;
      observe();
      if (!lsu_stall) begin
        left = 1; r_dmo = data_memory_output;
      end
      @(posedge clk); #1;
    end
    r_timeout = !left;
    mem_rd = 0; mem_wr = 0; bus_gnt = 0; bus_rvalid = 0;
    for (int t = 0; t < trail; t++) begin
      #1;
      observe();
      @(posedge clk); #1;
    end
  endtask

  task automatic verify(input string tag, input bit lg, input bit we, input logic [3:0] be,
                        input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] dmo,
                        input int stall, input int req);
    chk({tag, " timeout"}, 32'(r_timeout), 32'd0);
    chk({tag, " stall_cycles"}, 32'(r_stall), 32'(stall));
    chk({tag, " misaligned_cycles"}, 32'(r_mis), lg ? 32'd0 : 32'd1);
    chk({tag, " req_cycles"}, 32'(r_req), 32'(req));
    chk({tag, " dmo"}, r_dmo, dmo);
    if (lg) begin
      chk({tag, " bus_addr"}, r_addr, ad);
      chk({tag, " bus_be"}, 32'(r_be), 32'(be));
      chk({tag, " bus_we"}, 32'(r_we), 32'(we));
      if (we) chk({tag, " bus_wdata"}, r_wd, wd);
      chk({tag, " stable"}, 32'(r_stable), 32'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rd wr f3      addr          sdata         rdata         gd rdl lg be       bus_addr      wdata         dmo           stall
    vecs[0]  = mkv(1, 0, 3'b010, 32'h0000_0100, 32'h1122_3344, 32'hDEAD_BEEF, 0, 1, 1, 4'b1111, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 3);
    vecs[1]  = mkv(1, 0, 3'b000, 32'h0000_0103, 32'h0,         32'h8012_3456, 0, 1, 1, 4'b1000, 32'h0000_0100, 32'h0,        32'hFFFF_FF80, 3);
    vecs[2]  = mkv(1, 0, 3'b100, 32'h0000_0103, 32'h0,         32'h8012_3456, 0, 1, 1, 4'b1000, 32'h0000_0100, 32'h0,        32'h0000_0080, 3);
    vecs[3]  = mkv(1, 0, 3'b001, 32'h0000_0102, 32'h0,         32'h8012_3456, 0, 1, 1, 4'b1100, 32'h0000_0100, 32'h0,        32'hFFFF_8012, 3);
    vecs[4]  = mkv(1, 0, 3'b101, 32'h0000_0102, 32'h0,         32'h8012_3456, 0, 1, 1, 4'b1100, 32'h0000_0100, 32'h0,        32'h0000_8012, 3);
    vecs[5]  = mkv(0, 1, 3'b000, 32'h0000_0101, 32'h0000_00AB, 32'h5555_5555, 0, 1, 1, 4'b0010, 32'h0000_0100, 32'hABAB_ABAB, 32'h0000_8012, 3);
    vecs[6]  = mkv(0, 1, 3'b001, 32'h0000_0102, 32'h0000_BEEF, 32'h5555_5555, 0, 1, 1, 4'b1100, 32'h0000_0100, 32'hBEEF_BEEF, 32'h0000_8012, 3);
    vecs[7]  = mkv(0, 1, 3'b010, 32'h0000_0204, 32'h1357_9BDF, 32'h0,         2, 3, 1, 4'b1111, 32'h0000_0204, 32'h1357_9BDF, 32'h0000_8012, 7);
    vecs[8]  = mkv(1, 0, 3'b010, 32'h0000_0200, 32'h0,         32'hCAFE_F00D, 2, 3, 1, 4'b1111, 32'h0000_0200, 32'h0,        32'hCAFE_F00D, 7);
    vecs[9]  = mkv(1, 0, 3'b010, 32'h0000_0102, 32'h0,         32'h0,         0, 1, 0, 4'b0000, 32'h0,         32'h0,        32'hCAFE_F00D, 0);
    vecs[10] = mkv(1, 0, 3'b011, 32'h0000_0100, 32'h0,         32'h0,         0, 1, 0, 4'b0000, 32'h0,         32'h0,        32'hCAFE_F00D, 0);
    vecs[11] = mkv(0, 1, 3'b100, 32'h0000_0100, 32'h0,         32'h0,         0, 1, 0, 4'b0000, 32'h0,         32'h0,        32'hCAFE_F00D, 0);
    vecs[12] = mkv(1, 0, 3'b001, 32'h0000_0101, 32'h0,         32'h0,         0, 1, 0, 4'b0000, 32'h0,         32'h0,        32'hCAFE_F00D, 0);
    vecs[13] = mkv(1, 0, 3'b000, 32'h0000_0101, 32'h0,         32'h0000_7F00, 0, 1, 1, 4'b0010, 32'h0000_0100, 32'h0,        32'h0000_007F, 3);
    vecs[14] = mkv(1, 1, 3'b010, 32'h0000_0010, 32'hA5A5_0001, 32'hFFFF_FFFF, 1, 2, 1, 4'b1111, 32'h0000_0010, 32'hA5A5_0001, 32'h0000_007F, 5);

    // reset values, and no stall while reset is held
    rst = 1; mem_rd = 1; mem_wr = 0; funct3 = 3'b010; addr = 32'h100; store_data = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset stall", 32'(lsu_stall), 32'd0);
    rst = 0; mem_rd = 0;
    #1;
    chk("reset bus_req", 32'(bus_req), 32'd0);
    chk("reset bus_we", 32'(bus_we), 32'd0);
    chk("reset bus_addr", bus_addr, 32'd0);
    chk("reset bus_be", 32'(bus_be), 32'd0);
    chk("reset bus_wdata", bus_wdata, 32'd0);
    chk("reset dmo", data_memory_output, 32'd0);
    chk("reset misaligned", 32'(misaligned), 32'd0);
    @(posedge clk); #1;

    // directed table
    for (int i = 0; i < NV; i++) begin
      run_access(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].a, vecs[i].sd, vecs[i].rdat,
                 vecs[i].gd, vecs[i].rdl, 1, 0);
      verify($sformatf("vec%0d", i), vecs[i].lg, vecs[i].wr, vecs[i].be, vecs[i].ad,
             vecs[i].wd, vecs[i].dmo, vecs[i].stall, vecs[i].lg ? vecs[i].gd + 1 : 0);
    end
    model_dmo = vecs[NV-1].dmo;

    // back-to-back loads: the second starts in the IDLE cycle right after DONE
    begin
      bit lg; logic [3:0] ebe; logic [31:0] ewd, edmo;
      model(0, 3'b010, 32'h40, 32'h0, 32'h0BAD_F00D, model_dmo, lg, ebe, ewd, edmo);
      run_access(1, 0, 3'b010, 32'h40, 32'h0, 32'h0BAD_F00D, 0, 1, 0, 0);
      verify("b2b first", lg, 0, ebe, 32'h40, ewd, edmo, 3, 1);
      model_dmo = edmo;
      model(0, 3'b100, 32'h41, 32'h0, 32'h0000_9A00, model_dmo, lg, ebe, ewd, edmo);
      run_access(1, 0, 3'b100, 32'h41, 32'h0, 32'h0000_9A00, 0, 1, 1, 0);
      verify("b2b second", lg, 0, ebe, 32'h40, ewd, edmo, 3, 1);
      model_dmo = edmo;
    end

    // randomized accesses with random bus latency and stray rvalid noise
    for (int i = 0; i < 150; i++) begin
      bit rd, wr, lg;
      int kind, gd, rdl, tr;
      logic [2:0] f3;
      logic [31:0] a, sd, rdat, ewd, edmo;
      logic [3:0] ebe;
      kind = int'($urandom % 3);
      rd = (kind != 1); wr = (kind != 0);
      f3 = 3'($urandom % 8);
      a = $urandom; sd = $urandom; rdat = $urandom;
      gd = int'($urandom % 4); rdl = 1 + int'($urandom % 4);
      model(wr, f3, a, sd, rdat, model_dmo, lg, ebe, ewd, edmo);
      tr = lg ? int'($urandom % 2) : 1;
      run_access(rd, wr, f3, a, sd, rdat, gd, rdl, tr, 1);
      verify($sformatf("rand%0d", i), lg, wr, ebe, a & ~32'h3, ewd, edmo,
             lg ? 2 + gd + rdl : 0, lg ? gd + 1 : 0);
      model_dmo = edmo;
    end

    // reset in WAIT aborts the access; a late rvalid is ignored
    @(posedge clk); #1;
    mem_rd = 1; mem_wr = 0; funct3 = 3'b010; addr = 32'h300; store_data = 32'h77;
    bus_gnt = 0; bus_rvalid = 0;
    #1;
    chk("rstmid stall c0", 32'(lsu_stall), 32'd1);
    @(posedge clk); #1;
    chk("rstmid req", 32'(bus_req), 32'd1);
    bus_gnt = 1;
    @(posedge clk); #1;
    bus_gnt = 0;
    chk("rstmid wait stall", 32'(lsu_stall), 32'd1);
    rst = 1;
    #1;
    chk("rstmid stall in rst", 32'(lsu_stall), 32'd0);
    @(posedge clk); #1;
    rst = 0; mem_rd = 0;
    #1;
    chk("rstmid bus_req", 32'(bus_req), 32'd0);
    chk("rstmid bus_addr", bus_addr, 32'd0);
    chk("rstmid bus_be", 32'(bus_be), 32'd0);
    chk("rstmid dmo", data_memory_output, 32'd0);
    chk("rstmid stall", 32'(lsu_stall), 32'd0);
    bus_rvalid = 1; bus_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    bus_rvalid = 0;
    #1;
    chk("rstmid late rvalid dmo", data_memory_output, 32'd0);
    chk("rstmid late rvalid req", 32'(bus_req), 32'd0);
    @(posedge clk); #1;
    chk("rstmid late rvalid dmo2", data_memory_output, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
